// File: rtl/fast_command_pkg.sv
// fast_command_pkg: ETROC2 fast-command encodings, command codes and encoder FSM states
package fast_command_pkg;
  localparam logic [7:0] FC_IDLE      = 8'hF0;
  localparam logic [7:0] FC_LINKRESET = 8'hF8;
  localparam logic [7:0] FC_BCR       = 8'hF1;
  localparam logic [7:0] FC_SYNC_TRIG = 8'hF2;
  localparam logic [7:0] FC_L1A_CR    = 8'hF9;
  localparam logic [7:0] FC_CHARGEINJ = 8'hF4;
  localparam logic [7:0] FC_L1A       = 8'hF6;
  localparam logic [7:0] FC_L1A_BCR   = 8'hF3;
  localparam logic [7:0] FC_WS_START  = 8'hFC;
  localparam logic [7:0] FC_WS_STOP   = 8'hFA;

  typedef enum logic [3:0] {
    CMD_IDLE      = 4'd0,
    CMD_LINKRESET = 4'd1,
    CMD_BCR       = 4'd2,
    CMD_SYNC_TRIG = 4'd3,
    CMD_L1A_CR    = 4'd4,
    CMD_CHARGEINJ = 4'd5,
    CMD_L1A       = 4'd6,
    CMD_L1A_BCR   = 4'd7,
    CMD_WS_START  = 4'd8,
    CMD_WS_STOP   = 4'd9
  } cmd_e;

  typedef enum logic {ALIGN, RUN} state_e;

  function automatic logic [7:0] code_byte(input logic [3:0] code);
    case (code)
      CMD_LINKRESET: return FC_LINKRESET;
      CMD_BCR:       return FC_BCR;
      CMD_SYNC_TRIG: return FC_SYNC_TRIG;
      CMD_L1A_CR:    return FC_L1A_CR;
      CMD_CHARGEINJ: return FC_CHARGEINJ;
      CMD_L1A:       return FC_L1A;
      CMD_L1A_BCR:   return FC_L1A_BCR;
      CMD_WS_START:  return FC_WS_START;
      CMD_WS_STOP:   return FC_WS_STOP;
      default:       return FC_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/fast_command_bc_counter.sv
// fast_command_bc_counter: 12-bit bunch-crossing counter with orbit wrap, load-zero and hold
module fast_command_bc_counter #(
  parameter int BC_MAX = 3563
) (
  input  logic        clk320,
  input  logic        rstn,
  input  logic        hold,
  input  logic        load_zero,
  output logic [11:0] bcid,
  output logic        at_bc_max
);
  assign at_bc_max = bcid == 12'(BC_MAX);

  always_ff @(posedge clk320) begin
    if (!rstn) bcid <= '0;
    else if (load_zero) bcid <= '0;
    else if (!hold) bcid <= at_bc_max ? 12'd0 : bcid + 12'd1;
  end
endmodule

// File: rtl/fast_command_encoder.sv
// fast_command_encoder: command handshake to 8-bit fast-command bytes, MSB-first at 320 MHz
module fast_command_encoder
  import fast_command_pkg::*;
#(
  parameter int BC_MAX       = 3563,
  parameter int ALIGN_FRAMES = 16
) (
  input  logic        clk320,
  input  logic        rstn,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_code,
  output logic        cmd_ready,
  input  logic        auto_bcr_en,
  input  logic        align_req,
  output logic        fc,
  output logic        frame_start,
  output logic [11:0] bcid,
  output logic        aligning,
  output logic        cmd_err
);
  logic [7:0] shreg, align_cnt, run_byte, next_byte;
  logic [2:0] bit_cnt;
  logic [3:0] pend_code;
  logic       pend_v, align_flag, at_max, boundary, accept, accept_ok;
  logic       auto_bcr, consume, use_run, zero_bcid;
  state_e     state;

  assign fc          = shreg[7];
  assign frame_start = bit_cnt == 3'd0;
  assign aligning    = state == ALIGN;
  assign cmd_ready   = state == RUN && !pend_v;

  always_comb begin
    boundary  = bit_cnt == 3'd7;
    accept    = cmd_valid && cmd_ready;
    accept_ok = accept && cmd_code <= 4'd9;
    auto_bcr  = auto_bcr_en && at_max;
    run_byte  = auto_bcr ? (pend_v && pend_code == CMD_L1A ? FC_L1A_BCR : FC_BCR)
              : pend_v ? code_byte(pend_code) : FC_IDLE;
    consume   = pend_v && (!auto_bcr || pend_code == CMD_L1A);
    // the last preamble boundary already selects as RUN
    use_run   = state == RUN ? !align_flag
              : !align_flag && align_cnt == 8'(ALIGN_FRAMES - 1);
    next_byte = use_run ? run_byte : FC_IDLE;
    zero_bcid = boundary && (!use_run || next_byte == FC_BCR || next_byte == FC_L1A_BCR);
  end

  fast_command_bc_counter #(.BC_MAX(BC_MAX)) u_bc (
    .clk320   (clk320),
    .rstn     (rstn),
    .hold     (!boundary),
    .load_zero(zero_bcid),
    .bcid     (bcid),
    .at_bc_max(at_max)
  );

  always_ff @(posedge clk320) begin
    if (!rstn) begin
      shreg      <= FC_IDLE;
      bit_cnt    <= '0;
      state      <= ALIGN;
      align_cnt  <= '0;
      align_flag <= 1'b0;
      pend_v     <= 1'b0;
      pend_code  <= '0;
      cmd_err    <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= boundary ? next_byte : {shreg[6:0], shreg[7]};
      cmd_err <= accept && cmd_code > 4'd9;
      if (boundary) begin
        state      <= use_run ? RUN : ALIGN;
        align_cnt  <= use_run || align_flag ? 8'd0 : align_cnt + 8'd1;
        align_flag <= align_req;
      end else if (align_req) align_flag <= 1'b1;
      pend_v <= boundary && !use_run ? 1'b0 : accept_ok ? 1'b1 : boundary && consume ? 1'b0 : pend_v;
      if (accept_ok) pend_code <= cmd_code;
    end
  end
endmodule

// File: tb/tb_fast_command_encoder.sv
// tb_fast_command_encoder: directed checks of serialisation, handshake, auto BCR and alignment
module tb_fast_command_encoder;
  logic        clk320 = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_code = 4'd0;
  logic        auto_bcr_en = 1'b0;
  logic        align_req = 1'b0;
  logic        cmd_ready, fc, frame_start, aligning, cmd_err;
  logic [11:0] bcid;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  b;
  logic [11:0] id;
  logic        al, rd;
  logic [11:0] prev;

  fast_command_encoder #(.BC_MAX(9), .ALIGN_FRAMES(16)) dut (
    .clk320     (clk320),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .auto_bcr_en(auto_bcr_en),
    .align_req  (align_req),
    .fc         (fc),
    .frame_start(frame_start),
    .bcid       (bcid),
    .aligning   (aligning),
    .cmd_err    (cmd_err)
  );

  always #5 clk320 = ~clk320;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic get_frame(output logic [7:0] fb, output logic [11:0] fid, output logic fal, output logic frd);
    int n = 0;
    @(negedge clk320);
    while (!frame_start && n < 16) begin
      @(negedge clk320);
      n++;
    end
    chk("frame_sync", 12'(frame_start), 12'h1);
    fid = bcid;
    fal = aligning;
    frd = cmd_ready;
    fb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk320);
      fb = {fb[6:0], fc};
    end
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic ar);
    cmd_valid = 1'b1;
    cmd_code = c;
    align_req = ar;
    @(posedge clk320);
    #1;
    cmd_valid = 1'b0;
    align_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk320);
    @(negedge clk320);
    chk("rst_fc", 12'(fc), 12'h1);
    chk("rst_frame_start", 12'(frame_start), 12'h1);
    chk("rst_aligning", 12'(aligning), 12'h1);
    chk("rst_ready", 12'(cmd_ready), 12'h0);
    chk("rst_err", 12'(cmd_err), 12'h0);
    chk("rst_bcid", bcid, 12'h0);
    @(posedge clk320);
    #1 rstn = 1'b1;
    for (int f = 0; f < 16; f++) begin
      get_frame(b, id, al, rd);
      chk("pre_byte", 12'(b), 12'h0F0);
      chk("pre_aligning", 12'(al), 12'h1);
      chk("pre_bcid", id, 12'h0);
      chk("pre_ready", 12'(rd), 12'h0);
    end
    get_frame(b, id, al, rd);
    chk("run_aligning", 12'(al), 12'h0);
    chk("run_ready", 12'(rd), 12'h1);
    chk("run_bcid", id, 12'h1);
    chk("run_byte", 12'(b), 12'h0F0);

    repeat (4) @(negedge clk320);
    send_cmd(4'd6, 1'b0);
    chk("l1a_ready_busy", 12'(cmd_ready), 12'h0);
    repeat (4) @(negedge clk320);
    chk("l1a_ready_b7", 12'(cmd_ready), 12'h0);
    get_frame(b, id, al, rd);
    chk("l1a_byte", 12'(b), 12'h0F6);
    chk("l1a_ready_after", 12'(rd), 12'h1);
    chk("l1a_bcid", id, 12'h3);

    send_cmd(4'd12, 1'b0);
    chk("inv_err", 12'(cmd_err), 12'h1);
    chk("inv_ready", 12'(cmd_ready), 12'h1);
    @(posedge clk320);
    #1 chk("inv_err_clr", 12'(cmd_err), 12'h0);
    get_frame(b, id, al, rd);
    chk("inv_byte", 12'(b), 12'h0F0);
    chk("inv_bcid", id, 12'h5);

    auto_bcr_en = 1'b1;
    prev = 12'h5;
    for (int f = 0; f < 12; f++) begin
      prev = prev == 12'h9 ? 12'h0 : prev + 12'h1;
      get_frame(b, id, al, rd);
      chk("auto_bcid", id, prev);
      chk("auto_byte", 12'(b), prev == 12'h0 ? 12'h0F1 : 12'h0F0);
    end

    get_frame(b, id, al, rd);
    chk("pl1a_pre_bcid", id, 12'h8);
    send_cmd(4'd6, 1'b0);
    get_frame(b, id, al, rd);
    chk("pl1a_max_byte", 12'(b), 12'h0F0);
    chk("pl1a_max_bcid", id, 12'h9);
    chk("pl1a_max_ready", 12'(rd), 12'h0);
    get_frame(b, id, al, rd);
    chk("pl1a_bcr_byte", 12'(b), 12'h0F3);
    chk("pl1a_bcr_bcid", id, 12'h0);
    get_frame(b, id, al, rd);
    chk("pl1a_next_byte", 12'(b), 12'h0F0);
    chk("pl1a_next_ready", 12'(rd), 12'h1);
    for (int f = 2; f < 9; f++) begin
      get_frame(b, id, al, rd);
      chk("ws_pre_bcid", id, 12'(f));
    end
    send_cmd(4'd8, 1'b0);
    get_frame(b, id, al, rd);
    chk("ws_max_byte", 12'(b), 12'h0F0);
    get_frame(b, id, al, rd);
    chk("ws_bcr_byte", 12'(b), 12'h0F1);
    chk("ws_bcr_bcid", id, 12'h0);
    chk("ws_bcr_ready", 12'(rd), 12'h0);
    get_frame(b, id, al, rd);
    chk("ws_byte", 12'(b), 12'h0FC);
    chk("ws_bcid", id, 12'h1);

    auto_bcr_en = 1'b0;
    send_cmd(4'd1, 1'b1);
    get_frame(b, id, al, rd);
    chk("ar_first_byte", 12'(b), 12'h0F0);
    chk("ar_first_al", 12'(al), 12'h0);
    for (int f = 0; f < 16; f++) begin
      get_frame(b, id, al, rd);
      chk("ar_byte", 12'(b), 12'h0F0);
      chk("ar_bcid", id, 12'h0);
      chk("ar_al", 12'(al), 12'h1);
    end
    get_frame(b, id, al, rd);
    chk("ar_end_al", 12'(al), 12'h0);
    chk("ar_end_byte", 12'(b), 12'h0F0);
    chk("ar_end_bcid", id, 12'h1);
    chk("ar_end_ready", 12'(rd), 12'h1);

    repeat (4) @(negedge clk320);
    rstn = 1'b0;
    @(posedge clk320);
    #1 rstn = 1'b1;
    chk("mid_rst_fc", 12'(fc), 12'h1);
    chk("mid_rst_fs", 12'(frame_start), 12'h1);
    chk("mid_rst_al", 12'(aligning), 12'h1);
    chk("mid_rst_bcid", bcid, 12'h0);
    get_frame(b, id, al, rd);
    chk("mid_rst_byte", 12'(b), 12'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
